fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 113 +++++++++++
 tb/tb_fetch_unit.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: two-phase REQ/ISSUE instruction fetch with ack timeout and halt.
// Optional FETCH_BNE_EN: op 110 takes the branch target when zero=0.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [7:0]  op,
  output logic        instr_valid,
  input  logic        stall,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  output logic [31:0] pc,
  output logic        fault
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    REQ,
    ISSUE,
    HALT
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   seq_pc;
  logic [31:0]   br_pc;
  logic [31:0]   jmp_pc;
  logic [31:0]   next_pc;
  logic          take_br;

  assign op     = {5'b0, instr[26:24]};
  assign seq_pc = pc + 32'd4;
  assign br_pc  = seq_pc + {{14{instr[15]}}, instr[15:0], 2'b00};
  assign jmp_pc = {pc[31:26], instr[23:0], 2'b00};

`ifdef FETCH_BNE_EN
  assign take_br = (branch && zero) ||
                   (instr[26:24] == 3'b110 && !zero);
`else
  assign take_br = branch && zero;
`endif

  always_comb begin
    next_pc = seq_pc;
    priority case (1'b1)
      jump:    next_pc = jmp_pc;
      take_br: next_pc = br_pc;
      default: next_pc = seq_pc;
    endcase
  end

  // imem_req is low in the first post-reset cycle; acks there are ignored
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= REQ;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      instr       <= 32'd0;
      pc          <= RESET_PC;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
      cnt         <= '0;
    end else begin
      unique case (state)
        REQ: begin
          if (!imem_req) begin
            imem_req <= 1'b1;
          end else if (imem_ack) begin
            instr       <= imem_rdata;
            pc          <= imem_addr;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            cnt         <= '0;
            state       <= ISSUE;
          end else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
            fault    <= 1'b1;
            imem_req <= 1'b0;
            state    <= HALT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ISSUE: begin
          if (!stall) begin
            imem_addr   <= next_pc;
            imem_req    <= 1'b1;
            instr_valid <= 1'b0;
            state       <= REQ;
          end
        end
        HALT: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
        default: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          state       <= HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: vector table, hand sequences and a randomized run
// against a next-pc reference model for fetch_unit.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [7:0]  op;
  logic        instr_valid;
  logic        stall;
  logic        jump;
  logic        branch;
  logic        zero;
  logic [31:0] pc;
  logic        fault;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk),
    .reset(reset),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .instr(instr),
    .op(op),
    .instr_valid(instr_valid),
    .stall(stall),
    .jump(jump),
    .branch(branch),
    .zero(zero),
    .pc(pc),
    .fault(fault)
  );

  typedef struct {
    logic [31:0] p;
    logic [31:0] w;
    logic        j;
    logic        b;
    logic        z;
    logic [31:0] nxt;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] model_next(input logic [31:0] p,
      input logic [31:0] w, input logic j, input logic b, input logic z);
    int signed off;
    logic [31:0] tgt;
    off = int'($signed(w[15:0]));
    tgt = p + 32'd4 + 32'(off * 4);
    if (j) return (p & 32'hFC00_0000) | ((w & 32'h00FF_FFFF) << 2);
    if (b && z) return tgt;
`ifdef FETCH_BNE_EN
    if (w[26:24] == 3'd6 && !z) return tgt;
`endif
    return p + 32'd4;
  endfunction

  function automatic logic [31:0] jword(input logic [31:0] p);
    return 32'h0400_0000 | (p >> 2);
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    imem_ack = 1'b0;
    imem_rdata = 32'd0;
    stall = 1'b0;
    jump = 1'b0;
    branch = 1'b0;
    zero = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // waits for a request, holds ack low dly cycles, then returns w
  task automatic fetch(input logic [31:0] w, input int dly,
                       output logic [31:0] a);
    int n;
    n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", {31'd0, imem_req}, 32'd1);
    a = imem_addr;
    repeat (dly) @(negedge clk);
    imem_ack = 1'b1;
    imem_rdata = w;
    @(negedge clk);
    imem_ack = 1'b0;
    imem_rdata = 32'd0;
  endtask

  task automatic issue(input logic j, input logic b, input logic z);
    jump = j;
    branch = b;
    zero = z;
    stall = 1'b0;
    @(negedge clk);
    jump = 1'b0;
    branch = 1'b0;
    zero = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_t        v[8];
    logic [31:0] a;
    logic [31:0] w;
    logic [31:0] mpc;
    logic [31:0] hold_i;
    logic [31:0] hold_p;
    int          rc;

    v[0] = '{32'h10, 32'h0400_0040, 1'b1, 1'b0, 1'b0, 32'h100};
    v[1] = '{32'h20, 32'h0500_FFFE, 1'b0, 1'b1, 1'b1, 32'h1C};
    v[2] = '{32'h20, 32'h0500_FFFE, 1'b0, 1'b1, 1'b0, 32'h24};
`ifdef FETCH_BNE_EN
    v[3] = '{32'h20, 32'h0600_0003, 1'b0, 1'b0, 1'b0, 32'h30};
`else
    v[3] = '{32'h20, 32'h0600_0003, 1'b0, 1'b0, 1'b0, 32'h24};
`endif
    v[4] = '{32'h20, 32'h0600_0003, 1'b0, 1'b1, 1'b1, 32'h30};
    v[5] = '{32'h40, 32'h0100_0000, 1'b0, 1'b0, 1'b0, 32'h44};
    v[6] = '{32'h40, 32'h0500_0004, 1'b1, 1'b1, 1'b1, 32'h10};
    v[7] = '{32'h80, 32'h0700_0010, 1'b0, 1'b0, 1'b1, 32'h84};

    // reset state
    do_reset();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);

    // zero-wait throughput: valid every second cycle
    imem_ack = 1'b1;
    for (int c = 0; c < 6; c++) begin
      chk("tp_req", {31'd0, imem_req}, {31'd0, c[0]});
      chk("tp_valid", {31'd0, instr_valid},
          {31'd0, (c == 2 || c == 4)});
      if (c[0]) chk("tp_addr", imem_addr, 32'((c - 1) * 2));
      if (c == 2) chk("tp_op0", {24'd0, op}, 32'h01);
      if (c == 4) chk("tp_op1", {24'd0, op}, 32'h07);
      imem_rdata = (imem_addr == 32'h0) ? 32'h0100_0000 :
                   (imem_addr == 32'h4) ? 32'h0700_0005 : 32'h0;
      @(negedge clk);
    end
    imem_ack = 1'b0;

    // next-address vectors
    for (int i = 0; i < 8; i++) begin
      do_reset();
      fetch(jword(v[i].p), 0, a);
      issue(1'b1, 1'b0, 1'b0);
      fetch(v[i].w, i % 3, a);
      chk($sformatf("vec%0d_addr", i), a, v[i].p);
      chk($sformatf("vec%0d_pc", i), pc, v[i].p);
      chk($sformatf("vec%0d_op", i), {24'd0, op},
          {29'd0, v[i].w[26:24]});
      chk($sformatf("vec%0d_valid", i), {31'd0, instr_valid}, 32'd1);
      issue(v[i].j, v[i].b, v[i].z);
      chk($sformatf("vec%0d_next", i), imem_addr, v[i].nxt);
      chk($sformatf("vec%0d_req", i), {31'd0, imem_req}, 32'd1);
    end

    // stall holds the issued instruction, acks ignored meanwhile
    do_reset();
    fetch(32'h0700_0005, 0, a);
    for (int k = 0; k < 3; k++) begin
      stall = 1'b1;
      jump = 1'b1;
      imem_ack = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("st_instr", instr, 32'h0700_0005);
      chk("st_pc", pc, 32'h0);
      chk("st_op", {24'd0, op}, 32'h07);
      chk("st_valid", {31'd0, instr_valid}, 32'd1);
      chk("st_req", {31'd0, imem_req}, 32'd0);
    end
    imem_ack = 1'b0;
    issue(1'b0, 1'b0, 1'b0);
    chk("st_adv_addr", imem_addr, 32'h4);
    chk("st_adv_valid", {31'd0, instr_valid}, 32'd0);
    fetch(32'h0, 0, a);
    chk("st_adv_pc", pc, 32'h4);

    // wrap below zero, jump keeps pc[31:26]
    do_reset();
    fetch(32'h0500_FFFE, 0, a);
    issue(1'b0, 1'b1, 1'b1);
    chk("wrap_neg", imem_addr, 32'hFFFF_FFFC);
    fetch(32'h0400_0010, 0, a);
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    issue(1'b1, 1'b0, 1'b0);
    chk("wrap_jmp", imem_addr, 32'hFC00_0040);
    do_reset();
    fetch(32'h0500_FFFE, 0, a);
    issue(1'b0, 1'b1, 1'b1);
    fetch(32'h0, 0, a);
    issue(1'b0, 1'b0, 1'b0);
    chk("wrap_zero", imem_addr, 32'h0);

    // ack coincident with reset is discarded
    do_reset();
    @(negedge clk);
    reset = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("rack_instr", instr, 32'd0);
    chk("rack_valid", {31'd0, instr_valid}, 32'd0);
    chk("rack_req", {31'd0, imem_req}, 32'd0);
    imem_ack = 1'b0;

    // reset mid-issue abandons the instruction
    do_reset();
    fetch(jword(32'h40), 0, a);
    issue(1'b1, 1'b0, 1'b0);
    fetch(32'h0100_0000, 0, a);
    reset = 1'b1;
    @(negedge clk);
    chk("riss_valid", {31'd0, instr_valid}, 32'd0);
    chk("riss_pc", pc, 32'd0);
    chk("riss_addr", imem_addr, 32'd0);

    // ack timeout
    do_reset();
    rc = 0;
    for (int c = 0; c < 40 && !fault; c++) begin
      @(negedge clk);
      if (imem_req) rc++;
    end
    chk("to_cycles", 32'(rc), 32'd15);
    chk("to_fault", {31'd0, fault}, 32'd1);
    chk("to_req", {31'd0, imem_req}, 32'd0);
    imem_ack = 1'b1;
    repeat (3) @(negedge clk);
    chk("halt_req", {31'd0, imem_req}, 32'd0);
    chk("halt_valid", {31'd0, instr_valid}, 32'd0);
    chk("halt_fault", {31'd0, fault}, 32'd1);
    do_reset();
    chk("rec_fault", {31'd0, fault}, 32'd0);
    @(negedge clk);
    chk("rec_req", {31'd0, imem_req}, 32'd1);
    chk("rec_addr", imem_addr, 32'd0);

    // randomized run against the reference model
    do_reset();
    mpc = 32'd0;
    for (int k = 0; k < 200; k++) begin
      logic j, b, z;
      int   st;
      w  = $urandom;
      j  = ($urandom_range(0, 3) == 0);
      b  = 1'($urandom_range(0, 1));
      z  = 1'($urandom_range(0, 1));
      st = $urandom_range(0, 2);
      fetch(w, $urandom_range(0, 4), a);
      chk("rnd_addr", a, mpc);
      chk("rnd_instr", instr, w);
      chk("rnd_pc", pc, mpc);
      chk("rnd_op", {24'd0, op}, {29'd0, w[26:24]});
      hold_i = w;
      hold_p = mpc;
      for (int s = 0; s < st; s++) begin
        stall = 1'b1;
        jump = 1'($urandom_range(0, 1));
        branch = 1'($urandom_range(0, 1));
        zero = 1'($urandom_range(0, 1));
        imem_ack = 1'($urandom_range(0, 1));
        imem_rdata = $urandom;
        @(negedge clk);
        chk("rnd_st_instr", instr, hold_i);
        chk("rnd_st_pc", pc, hold_p);
        chk("rnd_st_valid", {31'd0, instr_valid}, 32'd1);
      end
      imem_ack = 1'b0;
      issue(j, b, z);
      mpc = model_next(mpc, w, j, b, z);
      chk("rnd_next", imem_addr, mpc);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
